dmem_loader: RTL and testbench
==============================

# dmem_loader

Host-side writer for the pipeline's data memory, the write-direction counterpart of the switch-addressed LED readout path. An operator enters bytes on eight switches and presses a load button. Every four presses assemble one 32-bit word. The block then asks the pipeline to hold, waits for the memory-port grant, and writes the word at an auto-incrementing 6-bit word address. It sits beside MEM, in front of the data-memory write-port mux.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronized cycles required to accept a new button level (range 1–2^20).
- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `Enable` input, 1 bit: level switch; 1 = loader active.
- `AddrBase` input, 6 bits: first word address, sampled on the IDLE→COLLECT transition.
- `Sw` input, 8 bits: byte value, sampled on an accepted press.
- `BtnLoad` input, 1 bit: raw, asynchronous push button.
- `Grant` input, 1 bit: memory-port mux has stalled the pipeline and routes the loader's write port.
- `HoldReq` output, 1 bit: request that the pipeline stall and hand over the memory port.
- `WrEn` output, 1 bit: one-cycle data-memory write strobe.
- `WrAddr` output, 6 bits: word address for the write.
- `WrData` output, 32 bits: assembled word.
- `ByteIdx` output, 2 bits: number of bytes collected so far in the current word (for LEDs).
- `Busy` output, 1 bit: 1 in every state except IDLE.

## Operation
- Button conditioning:
  - 2-flop synchronizer, then a stability counter.
  - The debounced level updates only after the synchronized level differs from it for `DEBOUNCE_CYCLES` consecutive cycles.
  - Any bounce restarts the count.
  - A rising edge of the debounced level produces a one-cycle `press` pulse. A falling edge produces nothing.
- FSM has states IDLE, COLLECT, REQ, WRITE.
- IDLE:
  - Outputs are idle.
  - When `Enable`=1, go to COLLECT, load `ptr`←`AddrBase`, `cnt`←0, `word`←0.
- COLLECT:
  - On `press`, load `word[31-8*cnt -: 8]`←`Sw`. Byte order is big-endian: the first press fills [31:24].
  - Increment `cnt`.
  - On the 4th press (`cnt`=3), go to REQ.
  - If `Enable`=0 (checked with priority over `press`), go to IDLE and discard the partial word.
- REQ:
  - `HoldReq`=1.
  - When `Grant`=1, go to WRITE.
  - `Enable`=0 does not abort REQ; the word is always written.
- WRITE:
  - For exactly one cycle: `WrEn`=1, `WrAddr`=`ptr`, `WrData`=`word`, `HoldReq`=1.
  - Then `ptr`←`ptr`+1. Modulo 64, so 63 wraps to 0.
  - `cnt`←0.
  - Go to COLLECT if `Enable`=1, else IDLE.
- Presses arriving in REQ, WRITE or IDLE are dropped. They are not queued.
- If `Grant` drops while in REQ, keep waiting. `Grant` is not sampled in WRITE.

## Timing
- Reset values of all outputs and state:
  - `HoldReq`=0, `WrEn`=0, `WrAddr`=0, `WrData`=0, `ByteIdx`=0, `Busy`=0.
  - FSM=IDLE.
  - Debounced level=0, stability counter=0.
- Reset mid-transfer abandons the word immediately. No write is issued.
- All outputs are registered, or decoded from registered state only.
- Press latency: `BtnLoad` rises before edge k and stays high. Then `press`=1 in the cycle after edge k+2+`DEBOUNCE_CYCLES`, and is high for exactly 1 cycle.
- Byte capture: `Sw` is sampled on the edge where `press`=1. `ByteIdx` updates on that same edge.
- After the 4th press, `HoldReq` rises on the next edge.
- Grant to write: `Grant` is sampled high at edge g. Then `WrEn`=1 during cycle g..g+1, and `HoldReq` falls at edge g+1. The minimum `HoldReq` duration is 2 cycles.
- `Grant` that is high before `HoldReq` is ignored.

## Structure
- Shared package / header `loader_defs`:
  - FSM state encodings (2 bits).
  - `LDR_ADDR_W`=6.
  - `LDR_BYTES`=4.
- Sub-module `btn_debounce`: synchronizer + stability counter + edge pulse. Parameter `DEBOUNCE_CYCLES`; outputs `level` and `press`.
- Top-level `dmem_loader`: FSM, byte shifter, address pointer.

## Test plan
- Reset, then `Enable`=1, `AddrBase`=5. Press with `Sw`=0x12, 0x34, 0x56, 0x78; `Grant` 3 cycles after `HoldReq`. Expect one `WrEn` pulse with `WrAddr`=5, `WrData`=0x12345678. Expect `ByteIdx` to step 0,1,2,3,0.
- Bounce: `BtnLoad` toggles every 3 cycles for 40 cycles, then holds high (`DEBOUNCE_CYCLES`=16). Expect exactly one `press`, `DEBOUNCE_CYCLES`+3 cycles after the final rising edge.
- Wrap: `AddrBase`=63, two full words 0xAABBCCDD and 0x01020304. Expect writes at 63 then 0.
- Abort: 2 bytes entered, `Enable`→0, then `Enable`→1 with `AddrBase`=10, and 4 new bytes. Expect a single write at 10 containing only the new bytes.
- `Enable`→0 during REQ, `Grant` arrives 5 cycles later. Expect the write to complete, then IDLE and `Busy`=0. Presses during REQ change nothing.
- `rst` asserted in REQ. Expect all outputs to drop immediately to their reset values, with no `WrEn`.

Source files
------------

// File: rtl/loader_defs.sv
// Shared definitions for the data-memory host loader.
// State encoding, sizes and the byte-insert helper.
package loader_defs;

    localparam int LDR_ADDR_W = 6;
    localparam int LDR_BYTES  = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_REQ     = 2'd2,
        ST_WRITE   = 2'd3
    } ldrState_t;

    // Big-endian fill: byte 0 lands in the top lane.
    function automatic logic [31:0] putByte(
        input logic [31:0] w,
        input logic [1:0]  idx,
        input logic [7:0]  b
    );
        logic [31:0] r;
        r = w;
        unique case (idx)
            2'd0: r[31:24] = b;
            2'd1: r[23:16] = b;
            2'd2: r[15:8]  = b;
            2'd3: r[7:0]   = b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchronizer, stability
// counter and a registered one-cycle rising-edge pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          levelD;
    logic [CW-1:0] stableCnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            level     <= 1'b0;
            levelD    <= 1'b0;
            press     <= 1'b0;
            stableCnt <= '0;
        end else begin
            sync1  <= btn;
            sync2  <= sync1;
            levelD <= level;
            press  <= level & ~levelD;
            // Any cycle agreeing with the current level restarts the count.
            if (sync2 == level) begin
                stableCnt <= '0;
            end else if (stableCnt == CNT_LAST) begin
                level     <= sync2;
                stableCnt <= '0;
            end else begin
                stableCnt <= stableCnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmem_loader.sv
// Switch-driven data-memory writer: four button presses build a
// big-endian word, written at an auto-incrementing word address.
module dmem_loader
    import loader_defs::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Enable,
    input  logic [LDR_ADDR_W-1:0] AddrBase,
    input  logic [7:0]            Sw,
    input  logic                  BtnLoad,
    input  logic                  Grant,
    output logic                  HoldReq,
    output logic                  WrEn,
    output logic [LDR_ADDR_W-1:0] WrAddr,
    output logic [31:0]           WrData,
    output logic [1:0]            ByteIdx,
    output logic                  Busy
);

    localparam logic [1:0] LAST_BYTE = 2'(LDR_BYTES - 1);

    ldrState_t             state;
    ldrState_t             stateNext;
    logic [LDR_ADDR_W-1:0] ptr;
    logic [LDR_ADDR_W-1:0] ptrNext;
    logic [1:0]            cnt;
    logic [1:0]            cntNext;
    logic [31:0]           word;
    logic [31:0]           wordNext;
    logic                  btnLevel;
    logic                  press;
    logic                  pressOk;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) uDebounce (
        .clk  (clk),
        .rst  (rst),
        .btn  (BtnLoad),
        .level(btnLevel),
        .press(press)
    );

    // A press only counts while the debounced button is still down.
    assign pressOk = press & btnLevel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            ptr   <= '0;
            cnt   <= '0;
            word  <= '0;
        end else begin
            state <= stateNext;
            ptr   <= ptrNext;
            cnt   <= cntNext;
            word  <= wordNext;
        end
    end

    always_comb begin
        stateNext = state;
        ptrNext   = ptr;
        cntNext   = cnt;
        wordNext  = word;
        unique case (state)
            ST_IDLE: begin
                if (Enable) begin
                    stateNext = ST_COLLECT;
                    ptrNext   = AddrBase;
                    cntNext   = '0;
                    wordNext  = '0;
                end
            end
            ST_COLLECT: begin
                if (!Enable) begin
                    stateNext = ST_IDLE;
                    cntNext   = '0;
                    wordNext  = '0;
                end else if (pressOk) begin
                    wordNext = putByte(word, cnt, Sw);
                    cntNext  = cnt + 1'b1;
                    if (cnt == LAST_BYTE) begin
                        stateNext = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (Grant) begin
                    stateNext = ST_WRITE;
                end
            end
            ST_WRITE: begin
                ptrNext   = ptr + 1'b1;
                cntNext   = '0;
                stateNext = Enable ? ST_COLLECT : ST_IDLE;
            end
        endcase
    end

    assign HoldReq = (state == ST_REQ) || (state == ST_WRITE);
    assign WrEn    = (state == ST_WRITE);
    assign WrAddr  = WrEn ? ptr : '0;
    assign WrData  = WrEn ? word : '0;
    assign ByteIdx = cnt;
    assign Busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_dmem_loader.sv
// Directed bench for dmem_loader: table of full-word writes plus
// hand sequences for bounce, abort, late disable and reset in REQ.
module tb_dmem_loader;

    localparam int D = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        Enable;
    logic [5:0]  AddrBase;
    logic [7:0]  Sw;
    logic        BtnLoad;
    logic        Grant;
    logic        HoldReq;
    logic        WrEn;
    logic [5:0]  WrAddr;
    logic [31:0] WrData;
    logic [1:0]  ByteIdx;
    logic        Busy;

    int nCmp = 0;
    int nBad = 0;

    typedef struct {
        bit          fromIdle;
        logic [5:0]  base;
        logic [31:0] bytesIn;
        int          grantDelay;
        logic [5:0]  expAddr;
        logic [31:0] expData;
    } vec_t;

    vec_t vecs[4];

    dmem_loader #(.DEBOUNCE_CYCLES(D)) dut (
        .clk     (clk),
        .rst     (rst),
        .Enable  (Enable),
        .AddrBase(AddrBase),
        .Sw      (Sw),
        .BtnLoad (BtnLoad),
        .Grant   (Grant),
        .HoldReq (HoldReq),
        .WrEn    (WrEn),
        .WrAddr  (WrAddr),
        .WrData  (WrData),
        .ByteIdx (ByteIdx),
        .Busy    (Busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pressByte(input logic [7:0] b);
        Sw = b;
        @(negedge clk);
        BtnLoad = 1'b1;
        cyc(D + 8);
        BtnLoad = 1'b0;
        cyc(D + 8);
    endtask

    task automatic doWrite(input int gd, input logic [5:0] a,
                           input logic [31:0] d);
        logic early;
        early = 1'b0;
        chk("hold_before_grant", {31'd0, HoldReq}, 32'd1);
        chk("no_wren_before_grant", {31'd0, WrEn}, 32'd0);
        repeat (gd) begin
            @(negedge clk);
            early |= WrEn;
        end
        chk("no_wren_while_waiting", {31'd0, early}, 32'd0);
        Grant = 1'b1;
        @(negedge clk);
        Grant = 1'b0;
        chk("wren_pulse", {31'd0, WrEn}, 32'd1);
        chk("wr_addr", {26'd0, WrAddr}, {26'd0, a});
        chk("wr_data", WrData, d);
        chk("hold_in_write", {31'd0, HoldReq}, 32'd1);
        @(negedge clk);
        chk("wren_single", {31'd0, WrEn}, 32'd0);
        chk("hold_drops", {31'd0, HoldReq}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1);
    end

    initial begin
        logic        early;
        logic        wrSeen;
        int          lat;
        logic [7:0]  b;

        vecs[0] = '{1'b1, 6'd5,  32'h12345678, 3, 6'd5,  32'h12345678};
        vecs[1] = '{1'b0, 6'd0,  32'hA0B1C2D3, 0, 6'd6,  32'hA0B1C2D3};
        vecs[2] = '{1'b1, 6'd63, 32'hAABBCCDD, 1, 6'd63, 32'hAABBCCDD};
        vecs[3] = '{1'b0, 6'd0,  32'h01020304, 2, 6'd0,  32'h01020304};

        rst = 1'b1;
        Enable = 1'b0;
        AddrBase = '0;
        Sw = '0;
        BtnLoad = 1'b0;
        Grant = 1'b0;
        cyc(2);
        chk("reset_ctrl", {26'd0, HoldReq, WrEn, ByteIdx, Busy}, 32'd0);
        chk("reset_addr", {26'd0, WrAddr}, 32'd0);
        chk("reset_data", WrData, 32'd0);
        rst = 1'b0;

        Grant = 1'b1;
        cyc(3);
        chk("stray_grant_busy", {31'd0, Busy}, 32'd0);
        chk("stray_grant_wren", {31'd0, WrEn}, 32'd0);
        Grant = 1'b0;

        for (int i = 0; i < 4; i++) begin
            if (vecs[i].fromIdle) begin
                Enable = 1'b0;
                cyc(2);
                chk("idle_busy", {31'd0, Busy}, 32'd0);
                AddrBase = vecs[i].base;
                Enable = 1'b1;
                cyc(1);
                chk("collect_busy", {31'd0, Busy}, 32'd1);
            end
            chk("byteidx_start", {30'd0, ByteIdx}, 32'd0);
            for (int j = 0; j < 4; j++) begin
                b = vecs[i].bytesIn[31 - 8*j -: 8];
                pressByte(b);
                chk("byteidx_step", {30'd0, ByteIdx}, (j + 1) % 4);
                if (j < 3) chk("no_hold_yet", {31'd0, HoldReq}, 32'd0);
            end
            doWrite(vecs[i].grantDelay, vecs[i].expAddr, vecs[i].expData);
        end

        Sw = 8'h5A;
        early = 1'b0;
        for (int i = 0; i < 40; i++) begin
            BtnLoad = ((i / 3) % 2) == 1;
            @(negedge clk);
            if (ByteIdx != 2'd0) early = 1'b1;
        end
        lat = 1;
        while (ByteIdx == 2'd0 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk("bounce_no_early", {31'd0, early}, 32'd0);
        chk("bounce_latency", lat, D + 4);
        BtnLoad = 1'b0;
        cyc(D + 8);
        chk("bounce_single", {30'd0, ByteIdx}, 32'd1);

        pressByte(8'h99);
        chk("abort_two_bytes", {30'd0, ByteIdx}, 32'd2);
        Enable = 1'b0;
        cyc(1);
        chk("abort_idle", {31'd0, Busy}, 32'd0);
        chk("abort_byteidx", {30'd0, ByteIdx}, 32'd0);
        cyc(2);
        AddrBase = 6'd10;
        Enable = 1'b1;
        cyc(1);
        pressByte(8'hDE);
        pressByte(8'hAD);
        pressByte(8'hBE);
        pressByte(8'hEF);
        doWrite(2, 6'd10, 32'hDEADBEEF);

        pressByte(8'h11);
        pressByte(8'h22);
        pressByte(8'h33);
        pressByte(8'h44);
        chk("req_hold", {31'd0, HoldReq}, 32'd1);
        Enable = 1'b0;
        pressByte(8'hFF);
        chk("req_press_byteidx", {30'd0, ByteIdx}, 32'd0);
        chk("req_still_hold", {31'd0, HoldReq}, 32'd1);
        chk("req_still_busy", {31'd0, Busy}, 32'd1);
        doWrite(5, 6'd11, 32'h11223344);
        chk("late_disable_idle", {31'd0, Busy}, 32'd0);

        AddrBase = 6'd20;
        Enable = 1'b1;
        cyc(1);
        pressByte(8'h01);
        pressByte(8'h02);
        pressByte(8'h03);
        pressByte(8'h04);
        chk("rst_req_hold", {31'd0, HoldReq}, 32'd1);
        Enable = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_ctrl", {26'd0, HoldReq, WrEn, ByteIdx, Busy}, 32'd0);
        chk("rst_async_data", WrData, 32'd0);
        Grant = 1'b1;
        wrSeen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            wrSeen |= WrEn;
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            wrSeen |= WrEn;
        end
        Grant = 1'b0;
        chk("rst_no_write", {31'd0, wrSeen}, 32'd0);
        chk("rst_after_idle", {31'd0, Busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
